// File: rtl/dlx_shift_pkg.sv
// Shared types and default sizes for the DLX multi-cycle shift unit.
// The arithmetic-right feature is gated by the SHIFT_SEQ_ARITH_EN macro in the sequencer.
package dlx_shift_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_AMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } shift_state_e;

  typedef enum logic [1:0] {
    STEP_LEFT        = 2'd0,
    STEP_RIGHT_LOG   = 2'd1,
    STEP_RIGHT_ARITH = 2'd2
  } step_dir_e;

endpackage

// File: rtl/dlx_shift_step.sv
// Combinational single-bit shift step: left, logical right or sign-replicating right.
module dlx_shift_step
  import dlx_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic             right,
  input  logic             arith,
  output logic [WIDTH-1:0] data_shifted
);

  step_dir_e dir_s;

  // Decode the step direction, then apply the one-bit shift.
  always_comb begin
    dir_s        = STEP_LEFT;
    data_shifted = data;
    if (right) begin
      if (arith) begin
        dir_s = STEP_RIGHT_ARITH;
      end else begin
        dir_s = STEP_RIGHT_LOG;
      end
    end else begin
      dir_s = STEP_LEFT;
    end
    case (dir_s)
      STEP_LEFT:        data_shifted = {data[WIDTH-2:0], 1'b0};
      STEP_RIGHT_LOG:   data_shifted = {1'b0, data[WIDTH-1:1]};
      STEP_RIGHT_ARITH: data_shifted = {data[WIDTH-1], data[WIDTH-1:1]};
      default:          data_shifted = data;
    endcase
  end

endmodule

// File: rtl/dlx_shift_sequencer.sv
// Multi-cycle shift sequencer: one shift step per clock until the amount is consumed.
// Define SHIFT_SEQ_ARITH_EN to enable the arithmetic right step (ARITH port otherwise ignored).
module dlx_shift_sequencer
  import dlx_shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic [AMT_W-1:0] AMOUNT,
  input  logic             RIGHT,
  input  logic             ARITH,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             BUSY,
  output logic             DONE
);

  shift_state_e     state_r;
  shift_state_e     state_next_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] step_data_s;
  logic [AMT_W-1:0] count_r;
  logic             right_r;
  logic             arith_r;
  logic             arith_in_s;
  logic             busy_r;
  logic             done_r;
  logic             load_s;
  logic             step_en_s;

`ifdef SHIFT_SEQ_ARITH_EN
  assign arith_in_s = ARITH;
`else
  logic unused_arith_s;
  assign unused_arith_s = ARITH;
  assign arith_in_s     = 1'b0;
`endif

  dlx_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data         (data_r),
    .right        (right_r),
    .arith        (arith_r),
    .data_shifted (step_data_s)
  );

  // Next-state and datapath-control decode.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          load_s = 1'b1;
          if (AMOUNT == {AMT_W{1'b0}}) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_en_s = 1'b1;
        if (count_r == {{(AMT_W-1){1'b0}}, 1'b1}) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register; BUSY/DONE are registered from the next state so they leave flops.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  // Operand capture on accept, one step per RUN cycle, hold otherwise.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_r  <= {WIDTH{1'b0}};
      count_r <= {AMT_W{1'b0}};
      right_r <= 1'b0;
      arith_r <= 1'b0;
    end else if (load_s) begin
      data_r  <= DATA_IN;
      count_r <= AMOUNT;
      right_r <= RIGHT;
      arith_r <= arith_in_s;
    end else if (step_en_s) begin
      data_r  <= step_data_s;
      count_r <= count_r - {{(AMT_W-1){1'b0}}, 1'b1};
    end else begin
      data_r  <= data_r;
      count_r <= count_r;
    end
  end

  assign DATA_OUT = data_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;

endmodule

// File: tb/tb_dlx_shift_sequencer.sv
// Self-checking bench for dlx_shift_sequencer: vector table, scoreboard queue, corner sequences.
module tb_dlx_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  amount;
  logic        right;
  logic        arith;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int checks;
  int passed;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] din;
    logic [4:0]  amt;
    logic        right;
    logic        arith;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  dlx_shift_sequencer dut (
    .CLK      (clk),
    .RESET    (reset),
    .START    (start),
    .DATA_IN  (data_in),
    .AMOUNT   (amount),
    .RIGHT    (right),
    .ARITH    (arith),
    .DATA_OUT (data_out),
    .BUSY     (busy),
    .DONE     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one request in cycle 0, then follow it cycle by cycle until DONE.
  task automatic run_vec(input vec_t v);
    bit          seen;
    logic [31:0] exp;
    @(negedge clk);
    data_in = v.din;
    amount  = v.amt;
    right   = v.right;
    arith   = v.arith;
    start   = 1'b1;
    sb_q.push_back(v.exp);
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("busy_during_op", 32'(busy), 32'd1);
      if (done) begin
        seen = 1'b1;
        chk("done_cycle", 32'(c), 32'(v.amt) + 32'd1);
        if (sb_q.size() > 0) begin
          exp = sb_q.pop_front();
          chk("result", data_out, exp);
        end else begin
          chk("scoreboard_nonempty", 32'd0, 32'd1);
        end
      end
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("result_hold", data_out, v.exp);
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    data_in = 32'd0;
    amount  = 5'd0;
    right   = 1'b0;
    arith   = 1'b0;

    vecs[0] = '{32'h0000_0001, 5'd4,  1'b0, 1'b0, 32'h0000_0010};
    vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001};
    vecs[2] = '{32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF};
`ifdef SHIFT_SEQ_ARITH_EN
    vecs[3] = '{32'h8000_0000, 5'd4,  1'b1, 1'b1, 32'hF800_0000};
    vecs[5] = '{32'h8765_4321, 5'd12, 1'b1, 1'b1, 32'hFFF8_7654};
`else
    vecs[3] = '{32'h8000_0000, 5'd4,  1'b1, 1'b1, 32'h0800_0000};
    vecs[5] = '{32'h8765_4321, 5'd12, 1'b1, 1'b1, 32'h0008_7654};
`endif
    vecs[4] = '{32'hF0F0_1234, 5'd8,  1'b0, 1'b0, 32'hF012_3400};
    vecs[6] = '{32'h7000_0001, 5'd3,  1'b1, 1'b1, 32'h0E00_0000};
    vecs[7] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 32'h8000_0000};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_data", data_out, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // START asserted during RUN must be ignored.
    @(negedge clk);
    data_in = 32'h0000_0001; amount = 5'd4; right = 1'b0; arith = 1'b0; start = 1'b1;
    sb_q.push_back(32'h0000_0010);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2 || c == 3) begin
        start = 1'b1; data_in = 32'hFFFF_FFFF; amount = 5'd0;
      end else begin
        start = 1'b0;
      end
      chk("ign_done_pattern", 32'(done), 32'(c == 5));
      chk("ign_busy_pattern", 32'(busy), 32'(c <= 5));
      if (done) begin
        chk("ign_result", data_out, sb_q.pop_front());
      end
    end
    chk("ign_hold", data_out, 32'h0000_0010);

    // START held high: accepts in cycles 0 and 4, DONE in cycles 3 and 7.
    @(negedge clk);
    data_in = 32'h0000_0003; amount = 5'd2; right = 1'b0; arith = 1'b0; start = 1'b1;
    sb_q.push_back(32'h0000_000C);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 4) begin
        sb_q.push_back(32'h0000_000C);
      end
      if (c >= 8) begin
        start = 1'b0;
      end
      chk("cont_done_pattern", 32'(done), 32'(c == 3 || c == 7));
      chk("cont_busy_pattern", 32'(busy), 32'(c != 4 && c < 8));
      if (done) begin
        if (sb_q.size() > 0) begin
          chk("cont_result", data_out, sb_q.pop_front());
        end else begin
          chk("cont_sb_nonempty", 32'd0, 32'd1);
        end
      end
    end
    chk("cont_sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset in cycle 2 of an 8-step shift aborts it with no DONE.
    @(negedge clk);
    data_in = 32'h1234_5678; amount = 5'd8; right = 1'b1; arith = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy_c3", 32'(busy), 32'd0);
    chk("abort_data_c3", data_out, 32'd0);
    for (int c = 4; c <= 14; c++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end

    // Unit still works after the abort.
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dlx_shift_sequencer.md
# dlx_shift_sequencer

Multi-bit shift unit for the DLX execute stage. Accepts a shift request (data, amount, direction), then applies a one-bit shift step once per clock until the requested amount is consumed. It reports BUSY while working and pulses DONE when finished. It is the controlling side of the single-bit shift datapath: it issues the SHIFT/RIGHT step commands the datapath only responds to. The ALU control stalls on BUSY.

## Interface
- WIDTH, 32, data width; must be a power of two.
- AMT_W, 5, shift-amount width, equal to log2(WIDTH).

- CLK  input  1  sole clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request strobe; sampled only in IDLE.
- DATA_IN  input  WIDTH  operand; captured with START.
- AMOUNT  input  AMT_W  shift count 0..WIDTH-1; captured with START.
- RIGHT  input  1  1 = right shift, 0 = left; captured with START.
- ARITH  input  1  1 = arithmetic right shift; captured with START. Used only when SHIFT_SEQ_ARITH_EN is defined.
- DATA_OUT  output  WIDTH  working/result register.
- BUSY  output  1  high whenever state is not IDLE.
- DONE  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with START=1:
  - Load data register ← DATA_IN and count ← AMOUNT.
  - Latch RIGHT and ARITH.
  - Next state is DONE if AMOUNT==0, else RUN.
- IDLE with START=0: hold all registers.
- RUN, each edge:
  - data ← step(data).
  - count ← count−1.
  - If count==1, next state is DONE.
- DONE: DONE=1 for exactly one cycle, then IDLE unconditionally. START is ignored in this state.
- START in RUN or DONE is ignored. Inputs are not re-sampled and there is no queueing.
- Step function:
  - Left: shift by one, 0 fills bit 0.
  - Logical right: shift by one, 0 fills bit WIDTH−1.
  - Arithmetic right: shift by one, bit WIDTH−1 replicated.
- DATA_OUT always shows the data register:
  - In RUN it shows intermediate values and is not a valid result.
  - It is valid from the DONE cycle and holds until the next accepted START.
- Reset values: state IDLE, DATA_OUT 0, count 0, BUSY 0, DONE 0, latched RIGHT/ARITH 0.
- RESET has priority over everything. RESET together with START means the request is dropped.
- RESET during RUN or DONE aborts the operation: no DONE pulse, and DATA_OUT = 0 in the next cycle.

## Timing
- START is presented in cycle 0 and sampled at the end of cycle 0.
- BUSY is high in cycles 1..AMOUNT+1.
- DONE is high in cycle AMOUNT+1 only.
- AMOUNT=0 gives a 1-cycle latency: DONE in cycle 1, and DATA_OUT = DATA_IN.
- Earliest next accept: START sampled in cycle AMOUNT+2. Holding START high gives back-to-back operations with one IDLE cycle between them.
- Maximum latency is WIDTH cycles (AMOUNT = WIDTH−1).
- There is no combinational path from any input to any output.

## Configuration
- SHIFT_SEQ_ARITH_EN defined: ARITH=1 together with RIGHT=1 selects the sign-replicating right step.
- SHIFT_SEQ_ARITH_EN undefined:
  - ARITH is unconnected internally.
  - All right shifts are logical.
  - The ARITH port remains present so the port list is identical in both builds.

## Structure
- Package dlx_shift_pkg holds:
  - WIDTH/AMT_W defaults.
  - The state enum (IDLE, RUN, DONE).
  - A step-direction typedef.
- Sub-module dlx_shift_step: combinational one-bit step with inputs data, RIGHT, ARITH and a one-bit-shifted output. It is instantiated once and feeds the data register.
- The sequencer contains only the FSM, counter and registers.

## Test plan
- Left shift: DATA_IN=0x0000_0001, AMOUNT=4, RIGHT=0 → BUSY in cycles 1–5, DONE in cycle 5, DATA_OUT=0x0000_0010.
- Maximum logical right shift: DATA_IN=0x8000_0000, AMOUNT=31, RIGHT=1, ARITH=0 → DONE in cycle 32, DATA_OUT=0x0000_0001.
- Zero amount: DATA_IN=0xDEAD_BEEF, AMOUNT=0 → DONE in cycle 1, DATA_OUT=0xDEAD_BEEF, BUSY high only in cycle 1.
- Arithmetic right: DATA_IN=0x8000_0000, AMOUNT=4, RIGHT=1, ARITH=1 → 0xF800_0000 with SHIFT_SEQ_ARITH_EN defined, 0x0800_0000 without it.
- Ignored START: a second START with DATA_IN=0xFFFF_FFFF during RUN → ignored, first result unchanged.
- Continuous START: START held high with AMOUNT=2 → accepts in cycles 0 and 4, DONE in cycles 3 and 7.
- Reset mid-operation: RESET in cycle 2 of an AMOUNT=8 operation → cycle 3 has BUSY=0 and DATA_OUT=0, and no DONE follows.
